// File: rtl/ssd_scan_controller.sv
// Iterative double-dabble to a 4-digit common-anode seven-segment scanner.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (ones always shown).
module ssd_scan_controller #(
  parameter int REFRESH_DIV = 100000,
  parameter int MAX_VALUE   = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [15:0] bcd,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [13:0] MAXV = 14'(MAX_VALUE);
  localparam logic [CW-1:0] RLAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LATCH
  } state_t;

  state_t state, state_nx;

  logic [29:0]   sr;
  logic [29:0]   sr_adj;
  logic [3:0]    cnt;
  logic [13:0]   vsat;
  logic [CW-1:0] rcnt;
  logic [1:0]    idx;
  logic [3:0]    an_nx;
  logic [3:0]    nib;
  logic [6:0]    seg_nx;
  logic          blank;

  assign dp   = 1'b1;
  assign vsat = (value > MAXV) ? MAXV : value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (load) state_nx = CONV;
      CONV:    if (cnt == 4'd13) state_nx = LATCH;
      LATCH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // add-3 on every BCD nibble >= 5 before the shift
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < 4; i++) begin
      if (sr[14+4*i +: 4] >= 4'd5)
        sr_adj[14+4*i +: 4] = sr[14+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      ovf  <= 1'b0;
      bcd  <= 16'h0000;
    end else begin
      done <= (state == LATCH);
      unique case (state)
        IDLE: begin
          if (load) begin
            sr   <= {16'h0000, vsat};
            ovf  <= (value > MAXV);
            cnt  <= '0;
            busy <= 1'b1;
          end
        end
        CONV: begin
          sr  <= {sr_adj[28:0], 1'b0};
          cnt <= cnt + 4'd1;
        end
        LATCH: begin
          bcd  <= sr[29:14];
          busy <= 1'b0;
        end
        default: busy <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt <= '0;
      idx  <= 2'd0;
    end else if (rcnt == RLAST) begin
      rcnt <= '0;
      idx  <= idx + 2'd1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  always_comb begin
    an_nx = 4'b1110;
    nib   = bcd[3:0];
    blank = 1'b0;
    unique case (idx)
      2'd0: begin
        an_nx = 4'b1110;
        nib   = bcd[3:0];
      end
      2'd1: begin
        an_nx = 4'b1101;
        nib   = bcd[7:4];
`ifdef LEADING_ZERO_BLANK_EN
        blank = (bcd[15:4] == 12'h000);
`endif
      end
      2'd2: begin
        an_nx = 4'b1011;
        nib   = bcd[11:8];
`ifdef LEADING_ZERO_BLANK_EN
        blank = (bcd[15:8] == 8'h00);
`endif
      end
      2'd3: begin
        an_nx = 4'b0111;
        nib   = bcd[15:12];
`ifdef LEADING_ZERO_BLANK_EN
        blank = (bcd[15:12] == 4'h0);
`endif
      end
      default: an_nx = 4'b1111;
    endcase
  end

  always_comb begin
    seg_nx = 7'b1111111;
    unique case (nib)
      4'd0:    seg_nx = 7'b1000000;
      4'd1:    seg_nx = 7'b1111001;
      4'd2:    seg_nx = 7'b0100100;
      4'd3:    seg_nx = 7'b0110000;
      4'd4:    seg_nx = 7'b0011001;
      4'd5:    seg_nx = 7'b0010010;
      4'd6:    seg_nx = 7'b0000010;
      4'd7:    seg_nx = 7'b1111000;
      4'd8:    seg_nx = 7'b0000000;
      4'd9:    seg_nx = 7'b0010000;
      default: seg_nx = 7'b1111111;
    endcase
    if (blank) seg_nx = 7'b1111111;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
    end else begin
      an  <= an_nx;
      seg <= seg_nx;
    end
  end

endmodule
